// File: rtl/cwd_issue_unit_if.sv
// Bus bundle for cwd_issue_unit: PSU codeword entry side plus qubit-driver beat side.
// slave = the issue unit, master = the environment that feeds entries and consumes beats.
// Optional feature macro of the unit: CWDISSUE_SKIPIDLE_EN.
`ifndef NUM_PQ
`define NUM_PQ 16
`endif
`ifndef CWD_BW
`define CWD_BW 8
`endif
`ifndef TIME_BW
`define TIME_BW 4
`endif
`ifndef OPCODE_BW
`define OPCODE_BW 4
`endif
`ifndef INVALID_OPCODE
`define INVALID_OPCODE 4'hF
`endif
`ifndef CWD_I
`define CWD_I 8'h00
`endif

interface cwd_issue_unit_if #(
    parameter int GRP_SIZE = 8,
    parameter int GRP_BW   = 4
);
    logic                          psu_valid;
    logic [`NUM_PQ*`CWD_BW-1:0]    cwdarray_in;
    logic [`TIME_BW-1:0]           timing_in;
    logic [`OPCODE_BW-1:0]         opcode_in;
    logic                          cwdgen_stall;
    logic                          issue_valid;
    logic [GRP_SIZE*`CWD_BW-1:0]   issue_cwd;
    logic [GRP_BW-1:0]             issue_grp;
    logic [`OPCODE_BW-1:0]         issue_opcode;
    logic                          issue_last;
    logic                          drv_ready;

    modport master (
        output psu_valid, cwdarray_in, timing_in, opcode_in, drv_ready,
        input  cwdgen_stall, issue_valid, issue_cwd, issue_grp, issue_opcode, issue_last
    );

    modport slave (
        input  psu_valid, cwdarray_in, timing_in, opcode_in, drv_ready,
        output cwdgen_stall, issue_valid, issue_cwd, issue_grp, issue_opcode, issue_last
    );
endinterface

// File: rtl/cwd_issue_unit.sv
// cwd_issue_unit: buffers PSU codeword entries in a small FIFO, waits each entry's timing
// field as idle cycles, then serialises the codeword array into GRP_SIZE-wide beats.
// Optional macro CWDISSUE_SKIPIDLE_EN: non-final groups whose codewords are all idle are skipped.
`ifndef NUM_PQ
`define NUM_PQ 16
`endif
`ifndef CWD_BW
`define CWD_BW 8
`endif
`ifndef TIME_BW
`define TIME_BW 4
`endif
`ifndef OPCODE_BW
`define OPCODE_BW 4
`endif
`ifndef INVALID_OPCODE
`define INVALID_OPCODE 4'hF
`endif
`ifndef CWD_I
`define CWD_I 8'h00
`endif

module cwd_issue_unit #(
    parameter int FIFO_ADDR_BW = 2,
    parameter int GRP_SIZE     = 8,
    parameter int GRP_BW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    cwd_issue_unit_if.slave  bus
);
    localparam int DEPTH   = 2**FIFO_ADDR_BW;
    localparam int NUM_GRP = (`NUM_PQ + GRP_SIZE - 1) / GRP_SIZE;
    localparam int CWD_BW  = `CWD_BW;
    localparam int ARR_W   = `NUM_PQ * CWD_BW;
    localparam int GRP_W   = GRP_SIZE * CWD_BW;
    localparam int PAD_W   = NUM_GRP * GRP_W;

    localparam logic [GRP_BW-1:0]       LAST_GRP   = GRP_BW'(NUM_GRP - 1);
    localparam logic [GRP_BW-1:0]       GRP_ONE    = 1;
    localparam logic [FIFO_ADDR_BW:0]   FULL_CNT   = (FIFO_ADDR_BW + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_BW:0]   CNT_ONE    = 1;
    localparam logic [FIFO_ADDR_BW-1:0] PTR_ONE    = 1;
    localparam logic [`TIME_BW-1:0]     TIMER_ONE  = 1;
    localparam logic [CWD_BW-1:0]       CWD_IDLE   = `CWD_I;

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    // Entry storage (no reset: contents are only meaningful below count_reg)
    logic [ARR_W-1:0]          cwd_mem    [DEPTH];
    logic [`TIME_BW-1:0]       timing_mem [DEPTH];
    logic [`OPCODE_BW-1:0]     opcode_mem [DEPTH];

    logic [FIFO_ADDR_BW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_ADDR_BW:0]     count_reg;
    logic                      stall, push, pop;

    state_t                    state_reg, state_next;
    logic [`TIME_BW-1:0]       timer_reg, timer_next;
    logic                      valid_reg, valid_next;
    logic [GRP_W-1:0]          cwd_reg, cwd_next;
    logic [GRP_BW-1:0]         grp_reg, grp_next;
    logic [`OPCODE_BW-1:0]     opcode_reg, opcode_next;
    logic                      last_reg, last_next;

    logic [PAD_W-1:0]          head_padded;
    logic [GRP_BW-1:0]         first_grp, next_grp;

    assign stall = (count_reg == FULL_CNT);
    assign push  = bus.psu_valid & ~stall;

    assign bus.cwdgen_stall = stall;
    assign bus.issue_valid  = valid_reg;
    assign bus.issue_cwd    = cwd_reg;
    assign bus.issue_grp    = grp_reg;
    assign bus.issue_opcode = opcode_reg;
    assign bus.issue_last   = last_reg;

    // Head entry widened to a whole number of groups; PQs beyond NUM_PQ read as idle
    for (genvar gi = 0; gi < NUM_GRP * GRP_SIZE; gi++) begin : g_pad
        if (gi < `NUM_PQ) begin : g_real
            assign head_padded[gi*CWD_BW +: CWD_BW] = cwd_mem[rd_ptr_reg][gi*CWD_BW +: CWD_BW];
        end else begin : g_fill
            assign head_padded[gi*CWD_BW +: CWD_BW] = CWD_IDLE;
        end
    end

`ifdef CWDISSUE_SKIPIDLE_EN
    logic [NUM_GRP-1:0] grp_idle;

    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_idle
        assign grp_idle[gi] = (head_padded[gi*GRP_W +: GRP_W] == {GRP_SIZE{CWD_IDLE}});
    end

    // Lowest non-idle group (from 0, and above the current one); final group is the fallback
    always_comb begin
        first_grp = LAST_GRP;
        next_grp  = LAST_GRP;
        for (int g = NUM_GRP - 2; g >= 0; g--) begin
            if (!grp_idle[g]) begin
                first_grp = GRP_BW'(g);
                if (GRP_BW'(g) > grp_reg) begin
                    next_grp = GRP_BW'(g);
                end
            end
        end
    end
`else
    assign first_grp = '0;
    assign next_grp  = grp_reg + GRP_ONE;
`endif

    // Capture entry at accept
    always_ff @(posedge clk) begin
        if (push) begin
            cwd_mem[wr_ptr_reg]    <= bus.cwdarray_in;
            timing_mem[wr_ptr_reg] <= bus.timing_in;
            opcode_mem[wr_ptr_reg] <= bus.opcode_in;
        end
    end

    // FIFO pointers and occupancy; a refused push never coincides with a counted push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Next-state and next-beat selection
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        valid_next  = valid_reg;
        cwd_next    = cwd_reg;
        grp_next    = grp_reg;
        opcode_next = opcode_reg;
        last_next   = last_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    timer_next = timing_mem[rd_ptr_reg];
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (timer_reg == '0) begin
                    state_next  = ISSUE;
                    valid_next  = 1'b1;
                    grp_next    = first_grp;
                    cwd_next    = head_padded[first_grp*GRP_W +: GRP_W];
                    opcode_next = opcode_mem[rd_ptr_reg];
                    last_next   = (first_grp == LAST_GRP);
                end else begin
                    timer_next = timer_reg - TIMER_ONE;
                end
            end
            ISSUE: begin
                if (valid_reg && bus.drv_ready) begin
                    if (last_reg) begin
                        pop        = 1'b1;
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        grp_next  = next_grp;
                        cwd_next  = head_padded[next_grp*GRP_W +: GRP_W];
                        last_next = (next_grp == LAST_GRP);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            valid_reg  <= 1'b0;
            cwd_reg    <= '0;
            grp_reg    <= '0;
            opcode_reg <= `INVALID_OPCODE;
            last_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            valid_reg  <= valid_next;
            cwd_reg    <= cwd_next;
            grp_reg    <= grp_next;
            opcode_reg <= opcode_next;
            last_reg   <= last_next;
        end
    end
endmodule

// File: tb/tb_cwd_issue_unit.sv
// Bench for cwd_issue_unit: scoreboard of expected beats fed at accept time, monitor compares
// each handshaken beat; directed latency/backpressure/reset cases then a randomized phase.
// Honours CWDISSUE_SKIPIDLE_EN when computing expected beats.
`ifndef NUM_PQ
`define NUM_PQ 16
`endif
`ifndef CWD_BW
`define CWD_BW 8
`endif
`ifndef TIME_BW
`define TIME_BW 4
`endif
`ifndef OPCODE_BW
`define OPCODE_BW 4
`endif
`ifndef INVALID_OPCODE
`define INVALID_OPCODE 4'hF
`endif
`ifndef CWD_I
`define CWD_I 8'h00
`endif

module tb_cwd_issue_unit;
    localparam int GRP_SIZE = 8;
    localparam int GRP_BW   = 4;
    localparam int NUM_GRP  = (`NUM_PQ + GRP_SIZE - 1) / GRP_SIZE;
    localparam int CWD_BW   = `CWD_BW;
    localparam int GRP_W    = GRP_SIZE * CWD_BW;
    localparam int ARR_W    = `NUM_PQ * CWD_BW;
    localparam int OPW      = `OPCODE_BW;

    typedef struct packed {
        logic [GRP_BW-1:0] grp;
        logic [GRP_W-1:0]  cwd;
        logic [OPW-1:0]    op;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cwd_issue_unit_if #(.GRP_SIZE(GRP_SIZE), .GRP_BW(GRP_BW)) bus ();

    cwd_issue_unit #(.FIFO_ADDR_BW(2), .GRP_SIZE(GRP_SIZE), .GRP_BW(GRP_BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats of one entry: each group in order, idle non-final groups dropped when skipping
    task automatic model_push(input logic [ARR_W-1:0] arr, input logic [OPW-1:0] op);
        logic [NUM_GRP*GRP_W-1:0] pad;
        beat_t b;
        logic  idle;
        for (int p = 0; p < NUM_GRP * GRP_SIZE; p++)
            pad[p*CWD_BW +: CWD_BW] = (p < `NUM_PQ) ? arr[p*CWD_BW +: CWD_BW] : `CWD_I;
        for (int g = 0; g < NUM_GRP; g++) begin
            b.grp  = GRP_BW'(g);
            b.cwd  = pad[g*GRP_W +: GRP_W];
            b.op   = op;
            b.last = (g == NUM_GRP - 1);
            idle = 1'b1;
            for (int i = 0; i < GRP_SIZE; i++)
                if (b.cwd[i*CWD_BW +: CWD_BW] != `CWD_I) idle = 1'b0;
`ifdef CWDISSUE_SKIPIDLE_EN
            if (idle && g != NUM_GRP - 1) continue;
`endif
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [ARR_W-1:0] rand_arr(input logic [NUM_GRP-1:0] idle_mask);
        logic [ARR_W-1:0] r;
        for (int p = 0; p < `NUM_PQ; p++)
            r[p*CWD_BW +: CWD_BW] = idle_mask[p/GRP_SIZE] ? `CWD_I : CWD_BW'($urandom);
        return r;
    endfunction

    // Monitor: records accepts into the scoreboard, compares handshaken beats, checks stall holds
    initial begin
        logic  hold_pend;
        beat_t held;
        beat_t cur;
        beat_t e;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            cur = '{grp: bus.issue_grp, cwd: bus.issue_cwd, op: bus.issue_opcode, last: bus.issue_last};
            if (hold_pend) begin
                check("hold_valid", bus.issue_valid, 1'b1);
                check("hold_cwd", cur.cwd, held.cwd);
                check("hold_grp", cur.grp, held.grp);
                check("hold_opcode", cur.op, held.op);
                check("hold_last", cur.last, held.last);
            end
            hold_pend = 1'b0;
            if (!rst) begin
                if (bus.psu_valid && !bus.cwdgen_stall)
                    model_push(bus.cwdarray_in, bus.opcode_in);
                if (bus.issue_valid && bus.drv_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got grp=%0d op=%0h expected no beat", cur.grp, cur.op);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_grp", cur.grp, e.grp);
                        check("beat_cwd", cur.cwd, e.cwd);
                        check("beat_opcode", cur.op, e.op);
                        check("beat_last", cur.last, e.last);
                    end
                end
                if (bus.issue_valid && !bus.drv_ready) begin
                    hold_pend = 1'b1;
                    held = cur;
                end
            end
        end
    end

    // Present one entry until accepted; returns the accepting edge number
    task automatic send(input logic [ARR_W-1:0] arr, input logic [`TIME_BW-1:0] t,
                        input logic [OPW-1:0] op, output int acc_edge);
        int g;
        bus.psu_valid   = 1'b1;
        bus.cwdarray_in = arr;
        bus.timing_in   = t;
        bus.opcode_in   = op;
        acc_edge = -1;
        g = 0;
        while (acc_edge < 0 && g < 400) begin
            @(negedge clk);
            if (!bus.cwdgen_stall) begin
                @(posedge clk);
                #1;
                acc_edge = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
            g++;
        end
        bus.psu_valid   = 1'b0;
        bus.cwdarray_in = ~arr;
        bus.opcode_in   = ~op;
        if (acc_edge < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 400 cycles");
        end
    endtask

    task automatic wait_first_beat(input int n_edge, input int lat, input string name);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.issue_valid && g < 100);
        check(name, cyc - n_edge, lat);
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || bus.issue_valid) && g < 3000) begin
            @(negedge clk);
            #1;
            g++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int g;
        bit done;
        logic [OPW-1:0] ops [5];
        logic [GRP_BW-1:0] exp_g;
        logic exp_l;

        bus.psu_valid   = 1'b0;
        bus.cwdarray_in = '0;
        bus.timing_in   = '0;
        bus.opcode_in   = '0;
        bus.drv_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state and quiet outputs
        @(negedge clk);
        check("rst_grp", bus.issue_grp, 0);
        check("rst_cwd", bus.issue_cwd, 0);
        check("rst_last", bus.issue_last, 0);
        repeat (10) begin
            check("rst_valid", bus.issue_valid, 0);
            check("rst_opcode", bus.issue_opcode, `INVALID_OPCODE);
            check("rst_stall", bus.cwdgen_stall, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // 2: timing 0, back-to-back beats at N+2 and N+3
        bus.drv_ready = 1'b1;
        send(rand_arr('0), 0, 4'h3, n);
        wait_first_beat(n, 2, "lat_t0");
        check("t0_first_grp", bus.issue_grp, 0);
        check("t0_first_last", bus.issue_last, 0);
        @(negedge clk);
        check("t0_second_edge", cyc - n, 3);
        check("t0_second_valid", bus.issue_valid, 1);
        check("t0_second_grp", bus.issue_grp, 1);
        check("t0_second_last", bus.issue_last, 1);
        @(negedge clk);
        check("t0_after_valid", bus.issue_valid, 0);
        wait_drain("t0_drain");
        @(posedge clk);
        #1;

        // 3: timing 5, then ready low three cycles with grp1 on the bus
        send(rand_arr('0), 5, 4'h7, n);
        wait_first_beat(n, 7, "lat_t5");
        @(posedge clk);
        #1 bus.drv_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.drv_ready = 1'b1;
        wait_drain("t5_drain");
        @(posedge clk);
        #1;

        // maximum timing value waits the full count
        send(rand_arr('0), {`TIME_BW{1'b1}}, 4'h9, n);
        wait_first_beat(n, 2 + (2**`TIME_BW - 1), "lat_tmax");
        wait_drain("tmax_drain");
        @(posedge clk);
        #1;

        // 4: fill with ready low, fifth entry held by stall, then release
        bus.drv_ready = 1'b0;
        for (int k = 0; k < 5; k++) ops[k] = OPW'(k + 1);
        for (int k = 0; k < 4; k++) send(rand_arr('0), `TIME_BW'($urandom_range(0, 2)), ops[k], n);
        bus.psu_valid   = 1'b1;
        bus.cwdarray_in = rand_arr('0);
        bus.timing_in   = 1;
        bus.opcode_in   = ops[4];
        repeat (5) begin
            @(negedge clk);
            check("full_stall", bus.cwdgen_stall, 1);
        end
        @(posedge clk);
        #1 bus.drv_ready = 1'b1;
        g = 0;
        done = 1'b0;
        while (!done && g < 200) begin
            @(negedge clk);
            if (!bus.cwdgen_stall) done = 1'b1;
            @(posedge clk);
            #1;
            g++;
        end
        bus.psu_valid = 1'b0;
        check("fifth_accepted", done, 1);
        wait_drain("fill_drain");
        @(posedge clk);
        #1;

        // 5: reset while the second of three entries is issuing
        for (int k = 0; k < 3; k++) send(rand_arr('0), 0, OPW'(k + 10), n);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(bus.issue_valid && bus.issue_opcode == OPW'(11)) && g < 100);
        check("entry2_seen", bus.issue_opcode, 11);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", bus.issue_valid, 0);
        check("midrst_opcode", bus.issue_opcode, `INVALID_OPCODE);
        check("midrst_stall", bus.cwdgen_stall, 0);
        check("midrst_grp", bus.issue_grp, 0);
        check("midrst_last", bus.issue_last, 0);
        check("midrst_cwd", bus.issue_cwd, 0);
        repeat (20) begin
            @(negedge clk);
            check("midrst_quiet", bus.issue_valid, 0);
        end
        @(posedge clk);
        #1;

        // 6: group 0 entirely idle
        send(rand_arr(2'b01), 0, 4'h5, n);
        wait_first_beat(n, 2, "idle0_lat");
`ifdef CWDISSUE_SKIPIDLE_EN
        exp_g = 1;
        exp_l = 1'b1;
`else
        exp_g = 0;
        exp_l = 1'b0;
`endif
        check("idle0_first_grp", bus.issue_grp, exp_g);
        check("idle0_first_last", bus.issue_last, exp_l);
        wait_drain("idle0_drain");
        @(posedge clk);
        #1;
        send(rand_arr(2'b10), 1, 4'h6, n);
        wait_drain("idle1_drain");
        @(posedge clk);
        #1;

        // randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    send(rand_arr(NUM_GRP'($urandom_range(0, 3))),
                         ($urandom_range(0, 7) == 0) ? {`TIME_BW{1'b1}} : `TIME_BW'($urandom_range(0, 3)),
                         OPW'($urandom_range(0, 14)), n);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.drv_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.drv_ready = 1'b1;
        wait_drain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
